// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter (and the matching receiver):
// frame size, default oversample ratio, FSM state encodings and a small helper
// for sizing the stop-bit period.
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int DATA_BITS          = 8;
  localparam int OVERSAMPLE_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // Number of baud ticks the line is held high for the stop bit(s).
  function automatic int unsigned stop_ticks(input int unsigned oversample,
                                             input int unsigned stop_bits);
    return oversample * stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Small synchronous FIFO buffering bytes between the host handshake and the
// transmit FSM. Full/empty come straight from the registered occupancy count,
// so they never depend combinationally on push/pop or the data.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        write wdata (ignored while full)
//   pop         drop the head entry (ignored while empty)
//   wdata       byte to store
//   rdata       current head entry (valid while !empty)
//   full/empty  occupancy flags
//   count       number of stored entries (0..DEPTH)
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count_q == FULL_COUNT);
  assign empty   = (count_q == {CNT_W{1'b0}});
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // Next-state for storage, pointers and occupancy; pointers wrap naturally
  // because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// UART transmitter: 8 data bits, no parity, LSB first, STOP_BITS stop bits.
// Bytes arrive over a valid/ready handshake into uart_tx_fifo and are
// serialised by a START/DATA/STOP FSM paced by the shared oversample tick.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   tx_tick        baud enable, OVERSAMPLE pulses per bit period
//   tx_data_in     byte to send
//   tx_data_valid  tx_data_in valid; accepted when tx_ready is high
//   tx_ready       FIFO has room (from registered occupancy)
//   uart_tx_out    serial line, idle high, driven directly from a flop
//   tx_busy        frame in progress or bytes still queued
// -----------------------------------------------------------------------------
module uart_tx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tx_tick,
  input  logic [DATA_BITS-1:0] tx_data_in,
  input  logic                 tx_data_valid,
  output logic                 tx_ready,
  output logic                 uart_tx_out,
  output logic                 tx_busy
);

  // Sample counter must reach STOP_BITS*OVERSAMPLE-1 (at most 2*OVERSAMPLE-1).
  localparam int SCNT_W = $clog2(2 * OVERSAMPLE);
  localparam int BCNT_W = $clog2(DATA_BITS);
  localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [SCNT_W-1:0] BIT_LAST     = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] STOP_LAST    = SCNT_W'(stop_ticks(OVERSAMPLE, STOP_BITS) - 1);
  localparam logic [BCNT_W-1:0] BIT_IDX_LAST = BCNT_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [SCNT_W-1:0]    sample_cnt_q, sample_cnt_d;
  logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_out_q, tx_out_d;

  logic                 fifo_pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FCNT_W-1:0]    fifo_count;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_data_valid),
    .pop   (fifo_pop),
    .wdata (tx_data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // All outputs derive from flops only: no path from tx_data_valid/tx_tick.
  assign tx_ready    = ~fifo_full;
  assign uart_tx_out = tx_out_q;
  assign tx_busy     = (state_q != ST_IDLE) | (fifo_count != {FCNT_W{1'b0}});

  // Frame sequencing: decides next line level, counters, shifter and pops.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_out_d     = tx_out_q;
    fifo_pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tx_out_d = 1'b1;
        // Launching on a tick makes the start bit exactly OVERSAMPLE ticks.
        if (tx_tick && !fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_d      = fifo_rdata;
          tx_out_d     = 1'b0;
          sample_cnt_d = {SCNT_W{1'b0}};
          state_d      = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_START: begin
        if (tx_tick) begin
          if (sample_cnt_q == BIT_LAST) begin
            tx_out_d     = shift_q[0];
            sample_cnt_d = {SCNT_W{1'b0}};
            bit_cnt_d    = {BCNT_W{1'b0}};
            state_d      = ST_DATA;
          end else begin
            sample_cnt_d = sample_cnt_q + SCNT_W'(1);
          end
        end else begin
          state_d = ST_START;
        end
      end

      ST_DATA: begin
        if (tx_tick) begin
          if (sample_cnt_q == BIT_LAST) begin
            sample_cnt_d = {SCNT_W{1'b0}};
            shift_d      = {1'b0, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q != BIT_IDX_LAST) begin
              // shift_q[1] becomes the new LSB after this shift.
              tx_out_d  = shift_q[1];
              bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            end else begin
              tx_out_d = 1'b1;
              state_d  = ST_STOP;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SCNT_W'(1);
          end
        end else begin
          state_d = ST_DATA;
        end
      end

      ST_STOP: begin
        if (tx_tick) begin
          if (sample_cnt_q == STOP_LAST) begin
            sample_cnt_d = {SCNT_W{1'b0}};
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              fifo_pop = 1'b1;
              shift_d  = fifo_rdata;
              tx_out_d = 1'b0;
              state_d  = ST_START;
            end else begin
              tx_out_d = 1'b1;
              state_d  = ST_IDLE;
            end
          end else begin
            sample_cnt_d = sample_cnt_q + SCNT_W'(1);
          end
        end else begin
          state_d = ST_STOP;
        end
      end

      default: begin
        tx_out_d     = 1'b1;
        sample_cnt_d = {SCNT_W{1'b0}};
        bit_cnt_d    = {BCNT_W{1'b0}};
        state_d      = ST_IDLE;
      end
    endcase
  end

  // FSM, counter, shifter and serial-line registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= {SCNT_W{1'b0}};
      bit_cnt_q    <= {BCNT_W{1'b0}};
      shift_q      <= {DATA_BITS{1'b0}};
      tx_out_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx_out_q     <= tx_out_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Self-checking bench for uart_tx. dut1 uses one stop bit, dut2 two stop bits
// with its own reset. Expected bytes are queued as they are pushed; a serial
// decoder pops and compares them as frames appear on the line.
// -----------------------------------------------------------------------------
module tb_uart_tx;

  localparam int OS      = 16;
  localparam int TICK_DIV = 4;
  localparam int BIT_CLK = OS * TICK_DIV;  // clocks per bit period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rst2_n;
  logic       tick_en, tick_man;
  logic       tick_div = 1'b0;
  int         div = 0;
  logic       tick;
  logic [7:0] data1, data2;
  logic       valid1, valid2;
  logic       ready1, out1, busy1;
  logic       ready2, out2, busy2;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp2_q[$];
  int         start_q[$];

  uart_tx #(.OVERSAMPLE(OS), .FIFO_DEPTH(4), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tx_tick(tick), .tx_data_in(data1),
    .tx_data_valid(valid1), .tx_ready(ready1), .uart_tx_out(out1), .tx_busy(busy1)
  );

  uart_tx #(.OVERSAMPLE(OS), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
    .clk(clk), .rst_n(rst2_n), .tx_tick(tick), .tx_data_in(data2),
    .tx_data_valid(valid2), .tx_ready(ready2), .uart_tx_out(out2), .tx_busy(busy2)
  );

  // Baud tick: one clock wide every TICK_DIV clocks, or a manual single pulse.
  assign tick = tick_man | (tick_en & tick_div);

  always @(negedge clk) begin
    tick_div <= (div == TICK_DIV - 1);
    div      <= (div == TICK_DIV - 1) ? 0 : div + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Decode one frame from the selected line; call at a negedge.
  task automatic rx_frame(input bit sel, input int timeout, output logic [7:0] b,
                          output bit got, output bit framing_ok, output int start_cyc);
    int n;
    got = 1'b0; framing_ok = 1'b1; b = 8'h00; start_cyc = 0; n = 0;
    while (((sel ? out2 : out1) !== 1'b0) && (n < timeout)) begin
      @(negedge clk); n++;
    end
    if ((sel ? out2 : out1) === 1'b0) begin
      got = 1'b1;
      start_cyc = cyc;
      repeat (BIT_CLK / 2) @(negedge clk);
      if ((sel ? out2 : out1) !== 1'b0) framing_ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (BIT_CLK) @(negedge clk);
        b[i] = sel ? out2 : out1;
      end
      repeat (BIT_CLK) @(negedge clk);
      if ((sel ? out2 : out1) !== 1'b1) framing_ok = 1'b0;
    end
  endtask

  // Offer a byte once ready is high; the byte is queued as expected output.
  task automatic push(input bit sel, input logic [7:0] b);
    int n;
    n = 0;
    while (((sel ? ready2 : ready1) !== 1'b1) && (n < 5000)) begin
      @(negedge clk); n++;
    end
    checks++;
    if ((sel ? ready2 : ready1) !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: tx_ready=%b for byte %02h, expected 1", sel ? ready2 : ready1, b);
    end else begin
      if (sel) begin
        data2 = b; valid2 = 1'b1; exp2_q.push_back(b);
      end else begin
        data1 = b; valid1 = 1'b1; exp_q.push_back(b);
      end
      @(negedge clk);
      valid1 = 1'b0;
      valid2 = 1'b0;
    end
  endtask

  // Wait for dut1 to finish all queued frames.
  task automatic wait_idle1(input string tag);
    int n;
    n = 0;
    while (((busy1 !== 1'b0) || (exp_q.size() != 0)) && (n < 8000)) begin
      @(negedge clk); n++;
    end
    checks++;
    if ((busy1 !== 1'b0) || (exp_q.size() != 0)) begin
      errors++;
      $display("FAIL %s_drain: tx_busy=%b pending=%0d, expected 0 and 0", tag, busy1, exp_q.size());
    end
  endtask

  // Scoreboard consumer for dut1.
  initial begin : monitor1
    logic [7:0] b;
    logic [7:0] e;
    bit         got;
    bit         fok;
    int         sc;
    @(negedge clk);
    forever begin
      rx_frame(1'b0, 256, b, got, fok, sc);
      if (got) begin
        start_q.push_back(sc);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL mon_unexpected: frame %02h, expected no frame", b);
        end else begin
          e = exp_q.pop_front();
          if (b !== e) begin
            errors++;
            $display("FAIL mon_byte: got %02h, expected %02h", b, e);
          end
        end
        checks++;
        if (!fok) begin
          errors++;
          $display("FAIL mon_framing: start/stop ok=%0d, expected 1 (byte %02h)", fok, b);
        end
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (out1 !== 1'b1) begin errors++; $display("FAIL reset_out: got %b, expected 1", out1); end
    checks++;
    if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, expected 1", ready1); end
    checks++;
    if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", busy1); end
    rst_n = 1'b1;
    rst2_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    int  t;
    int  low_n;
    bit  seen_high;
    tick_en = 1'b1;
    push(1'b0, 8'hA5);
    t = 0;
    while ((out1 !== 1'b0) && (t < 200)) begin @(negedge clk); t++; end
    checks++;
    if (out1 !== 1'b0) begin
      errors++;
      $display("FAIL single_start: line=%b after %0d clk, expected 0", out1, t);
    end else begin
      t = 0; low_n = 0; seen_high = 1'b0;
      while ((busy1 === 1'b1) && (t < 2000)) begin
        if (!seen_high && (out1 === 1'b0)) low_n++;
        else seen_high = 1'b1;
        @(negedge clk); t++;
      end
      checks++;
      if (low_n != BIT_CLK) begin
        errors++; $display("FAIL single_start_len: got %0d clk, expected %0d", low_n, BIT_CLK);
      end
      checks++;
      if (t != 10 * BIT_CLK) begin
        errors++; $display("FAIL single_frame_len: got %0d clk, expected %0d", t, 10 * BIT_CLK);
      end
    end
    wait_idle1("single");
    checks++;
    if ((out1 !== 1'b1) || (ready1 !== 1'b1)) begin
      errors++; $display("FAIL single_idle: line=%b ready=%b, expected 1 1", out1, ready1);
    end
  endtask

  task automatic test_fifo_full();
    tick_en = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 4; i++) push(1'b0, 8'(i));
    checks++;
    if (ready1 !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, expected 0", ready1); end
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL full_busy: got %b, expected 1", busy1); end
    repeat (20) @(negedge clk);
    checks++;
    if (out1 !== 1'b1) begin errors++; $display("FAIL full_no_tick: line=%b, expected 1", out1); end
    tick_en = 1'b1;
    push(1'b0, 8'h05);
    wait_idle1("fifo_full");
  endtask

  task automatic test_back_to_back();
    start_q.delete();
    push(1'b0, 8'h3C);
    push(1'b0, 8'hC3);
    wait_idle1("b2b");
    checks++;
    if (start_q.size() != 2) begin
      errors++; $display("FAIL b2b_frames: got %0d frames, expected 2", start_q.size());
    end else begin
      checks++;
      if ((start_q[1] - start_q[0]) != 10 * BIT_CLK) begin
        errors++;
        $display("FAIL b2b_gap: start spacing %0d clk, expected %0d", start_q[1] - start_q[0], 10 * BIT_CLK);
      end
    end
  endtask

  task automatic test_push_pop();
    tick_en = 1'b0;
    @(negedge clk);
    push(1'b0, 8'h11);
    push(1'b0, 8'h22);
    push(1'b0, 8'h33);
    // One cycle with both a push and a tick-driven pop at occupancy 3.
    data1 = 8'h44; valid1 = 1'b1; tick_man = 1'b1; exp_q.push_back(8'h44);
    @(negedge clk);
    valid1 = 1'b0; tick_man = 1'b0;
    checks++;
    if (ready1 !== 1'b1) begin errors++; $display("FAIL pp_ready: got %b, expected 1", ready1); end
    checks++;
    if (out1 !== 1'b0) begin errors++; $display("FAIL pp_start: line=%b, expected 0", out1); end
    push(1'b0, 8'h55);
    checks++;
    if (ready1 !== 1'b0) begin errors++; $display("FAIL pp_count: ready=%b after one push, expected 0", ready1); end
    tick_en = 1'b1;
    wait_idle1("push_pop");
  endtask

  task automatic test_stop2();
    logic [7:0] b;
    logic [7:0] e;
    bit         got;
    bit         fok;
    int         sc[2];
    int         n;
    push(1'b1, 8'hFF);
    push(1'b1, 8'h5A);
    for (int k = 0; k < 2; k++) begin
      rx_frame(1'b1, 400, b, got, fok, sc[k]);
      checks++;
      if (!got) begin
        errors++; $display("FAIL stop2_frame%0d: no start bit, expected frame", k);
      end else begin
        e = exp2_q.pop_front();
        checks++;
        if ((b !== e) || !fok) begin
          errors++; $display("FAIL stop2_byte%0d: got %02h ok=%0d, expected %02h ok=1", k, b, fok, e);
        end
      end
    end
    checks++;
    if ((sc[1] - sc[0]) != 11 * BIT_CLK) begin
      errors++; $display("FAIL stop2_gap: start spacing %0d clk, expected %0d", sc[1] - sc[0], 11 * BIT_CLK);
    end
    n = 0;
    while ((busy2 !== 1'b0) && (n < 2000)) begin @(negedge clk); n++; end
    checks++;
    if ((busy2 !== 1'b0) || (out2 !== 1'b1)) begin
      errors++; $display("FAIL stop2_idle: busy=%b line=%b, expected 0 1", busy2, out2);
    end
  endtask

  task automatic test_reset_mid();
    int t;
    int bad;
    push(1'b1, 8'h00);
    t = 0;
    while ((out2 !== 1'b0) && (t < 200)) begin @(negedge clk); t++; end
    checks++;
    if (out2 !== 1'b0) begin
      errors++; $display("FAIL rstmid_start: line=%b, expected 0", out2);
    end else begin
      // Centre of data bit 4: start bit plus four data bits plus half a bit.
      repeat (5 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
      checks++;
      if (out2 !== 1'b0) begin errors++; $display("FAIL rstmid_bit4: line=%b, expected 0", out2); end
      rst2_n = 1'b0;
      #1;
      checks++;
      if ((out2 !== 1'b1) || (ready2 !== 1'b1) || (busy2 !== 1'b0)) begin
        errors++;
        $display("FAIL rstmid_async: line=%b ready=%b busy=%b, expected 1 1 0", out2, ready2, busy2);
      end
      @(negedge clk);
      rst2_n = 1'b1;
    end
    exp2_q.delete();
    bad = 0;
    repeat (12 * BIT_CLK) begin
      @(negedge clk);
      if ((out2 !== 1'b1) || (busy2 !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rstmid_residual: %0d cycles active after reset, expected 0", bad);
    end
  endtask

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    tick_en = 1'b0; tick_man = 1'b0;
    data1 = 8'h00; data2 = 8'h00;
    valid1 = 1'b0; valid2 = 1'b0;
    test_reset();
    test_single();
    test_fifo_full();
    test_back_to_back();
    test_push_pop();
    test_stop2();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
